// File: rtl/dut_cmd_gen_pkg.sv
// Shared types and helpers for the deterministic cmd/adr/data sweep generator.
package dut_cmd_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED     = 2'd0,
    MODE_CMD_SWEEP = 2'd1,
    MODE_CROSS     = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] CMD_NOP = 4'd0;

  // Commands cycle through 1..15 so a sweep never emits the NOP encoding.
  function automatic logic [3:0] cmd_inc(input logic [3:0] c);
    if (c == 4'd15) begin
      return 4'd1;
    end else begin
      return c + 4'd1;
    end
  endfunction

  function automatic logic [3:0] lfsr4_next(input logic [3:0] d);
    return {d[2:0], d[3] ^ d[2]};
  endfunction

endpackage

// File: rtl/dut_cmd_gen_if.sv
// Command bundle sampled by coverage collectors; the generator drives it as master.
interface dut_if #(
  parameter int CMD_W  = 4,
  parameter int ADR_W  = 4,
  parameter int DATA_W = 4
);
  logic [CMD_W-1:0]  cmd;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] data;
  logic              valid;

  modport master (output cmd, output adr, output data, output valid);
  modport slave  (input cmd, input adr, input data, input valid);
endinterface

// File: rtl/dut_cmd_gen_lfsr.sv
// 4-bit write-data LFSR (x^4+x^3+1); a zero seed is forced to 1 so it never locks up.
module dut_cmd_lfsr
  import dut_cmd_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [DATA_W-1:0] i_seed,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_lfsr;
  logic [DATA_W-1:0] w_seed;

  assign w_seed = (i_seed == {DATA_W{1'b0}}) ? DATA_W'(1'b1) : i_seed;

  // Load wins over advance; otherwise the value holds (e.g. through gap cycles).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= {DATA_W{1'b0}};
    end else if (i_load) begin
      r_lfsr <= w_seed;
    end else if (i_adv) begin
      r_lfsr <= lfsr4_next(r_lfsr);
    end
  end

  assign o_data = r_lfsr;

endmodule

// File: rtl/dut_cmd_gen.sv
// Programmable command/address sweep generator; every output comes straight from a register.
module dut_cmd_gen
  import dut_cmd_pkg::*;
#(
  parameter int CMD_W  = 4,
  parameter int ADR_W  = 4,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_mode,
  input  logic [CMD_W-1:0]  i_cmd_sel,
  input  logic [ADR_W-1:0]  i_adr_start,
  input  logic [ADR_W-1:0]  i_adr_stride,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [3:0]        i_gap,
  input  logic [DATA_W-1:0] i_data_seed,
  dut_if.master             bus,
  output logic              o_busy,
  output logic              o_done
);

  state_e            r_state, w_state_n;
  logic [1:0]        r_mode;
  logic [ADR_W-1:0]  r_adr_start, r_stride;
  logic [CNT_W-1:0]  r_count, r_i, w_i_n, w_i_inc;
  logic [3:0]        r_gap, r_gap_cnt;
  logic [CMD_W-1:0]  r_beat_cmd, w_beat_cmd_n, w_step_cmd, w_c0;
  logic [ADR_W-1:0]  r_beat_adr, w_beat_adr_n, w_step_adr;
  logic [CMD_W-1:0]  r_cmd, w_cmd_n;
  logic [ADR_W-1:0]  r_adr, w_adr_n;
  logic              r_valid, r_busy, r_done;
  logic              w_valid_n, w_busy_n, w_done_n;
  logic              w_lfsr_load, w_lfsr_adv, w_last, w_wrap16;
  logic [DATA_W-1:0] w_data;

  assign w_c0     = (i_cmd_sel == {CMD_W{1'b0}}) ? CMD_W'(1'b1) : i_cmd_sel;
  assign w_i_inc  = r_i + CNT_W'(1'b1);
  assign w_last   = (r_i == r_count - CNT_W'(1'b1));
  assign w_wrap16 = (w_i_inc[3:0] == 4'd0);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_n = (i_count == {CNT_W{1'b0}}) ? ST_DONE : ST_ISSUE;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_abort) begin
          w_state_n = ST_IDLE;
        end else if (w_last) begin
          w_state_n = ST_DONE;
        end else if (r_gap != 4'd0) begin
          w_state_n = ST_GAP;
        end else begin
          w_state_n = ST_ISSUE;
        end
      end
      ST_GAP: begin
        if (i_abort) begin
          w_state_n = ST_IDLE;
        end else if (r_gap_cnt == 4'd0) begin
          w_state_n = ST_ISSUE;
        end else begin
          w_state_n = ST_GAP;
        end
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Values of beat i+1 derived from beat i; CROSS restarts the address every 16 beats.
  always_comb begin
    w_step_cmd = r_beat_cmd;
    w_step_adr = r_beat_adr + r_stride;
    case (r_mode)
      MODE_CMD_SWEEP: w_step_cmd = cmd_inc(r_beat_cmd);
      MODE_CROSS: begin
        if (w_wrap16) begin
          w_step_cmd = cmd_inc(r_beat_cmd);
          w_step_adr = r_adr_start;
        end else begin
          w_step_cmd = r_beat_cmd;
        end
      end
      default: w_step_cmd = r_beat_cmd;
    endcase
  end

  // Output and beat-tracking decode, evaluated against the state being entered.
  always_comb begin
    w_i_n        = r_i;
    w_beat_cmd_n = r_beat_cmd;
    w_beat_adr_n = r_beat_adr;
    w_lfsr_load  = 1'b0;
    w_lfsr_adv   = 1'b0;
    w_cmd_n      = CMD_NOP;
    w_adr_n      = r_adr;
    w_valid_n    = 1'b0;
    w_busy_n     = 1'b0;
    w_done_n     = 1'b0;
    if (r_state == ST_IDLE) begin
      if (i_start) begin
        w_i_n        = {CNT_W{1'b0}};
        w_beat_cmd_n = w_c0;
        w_beat_adr_n = i_adr_start;
        w_lfsr_load  = (i_count != {CNT_W{1'b0}});
      end else begin
        w_i_n = r_i;
      end
    end else if (w_state_n == ST_ISSUE) begin
      w_i_n        = w_i_inc;
      w_beat_cmd_n = w_step_cmd;
      w_beat_adr_n = w_step_adr;
      w_lfsr_adv   = 1'b1;
    end else begin
      w_i_n = r_i;
    end
    case (w_state_n)
      ST_ISSUE: begin
        w_cmd_n   = w_beat_cmd_n;
        w_adr_n   = w_beat_adr_n;
        w_valid_n = 1'b1;
        w_busy_n  = 1'b1;
      end
      ST_GAP:  w_busy_n = 1'b1;
      ST_DONE: begin
        w_busy_n = 1'b1;
        w_done_n = 1'b1;
      end
      default: w_busy_n = 1'b0;
    endcase
  end

  // Run configuration, captured only when a run is launched.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode      <= 2'd0;
      r_adr_start <= {ADR_W{1'b0}};
      r_stride    <= {ADR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_gap       <= 4'd0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_mode      <= i_mode;
      r_adr_start <= i_adr_start;
      r_stride    <= i_adr_stride;
      r_count     <= i_count;
      r_gap       <= i_gap;
    end
  end

  // Beat index, current beat values and gap countdown.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i        <= {CNT_W{1'b0}};
      r_beat_cmd <= {CMD_W{1'b0}};
      r_beat_adr <= {ADR_W{1'b0}};
      r_gap_cnt  <= 4'd0;
    end else begin
      r_i        <= w_i_n;
      r_beat_cmd <= w_beat_cmd_n;
      r_beat_adr <= w_beat_adr_n;
      if ((r_state == ST_ISSUE) && (w_state_n == ST_GAP)) begin
        r_gap_cnt <= r_gap - 4'd1;
      end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
        r_gap_cnt <= r_gap_cnt - 4'd1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd   <= {CMD_W{1'b0}};
      r_adr   <= {ADR_W{1'b0}};
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cmd   <= w_cmd_n;
      r_adr   <= w_adr_n;
      r_valid <= w_valid_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  dut_cmd_lfsr #(.DATA_W(DATA_W)) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_lfsr_load),
    .i_adv  (w_lfsr_adv),
    .i_seed (i_data_seed),
    .o_data (w_data)
  );

  assign bus.cmd   = r_cmd;
  assign bus.adr   = r_adr;
  assign bus.data  = w_data;
  assign bus.valid = r_valid;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_dut_cmd_gen.sv
// Bench for dut_cmd_gen: per-cycle comparison against a run-plan model plus literal trace checks.
module tb_dut_cmd_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] cmd_sel = 4'd0;
  logic [3:0] adr_start = 4'd0;
  logic [3:0] adr_stride = 4'd0;
  logic [7:0] count = 8'd0;
  logic [3:0] gap = 4'd0;
  logic [3:0] seed = 4'd0;
  logic       busy, done;

  dut_if bus ();

  dut_cmd_gen dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_abort      (abort),
    .i_mode       (mode),
    .i_cmd_sel    (cmd_sel),
    .i_adr_start  (adr_start),
    .i_adr_stride (adr_stride),
    .i_count      (count),
    .i_gap        (gap),
    .i_data_seed  (seed),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] adr;
    logic [3:0] data;
    logic       valid;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_o = '0;
  obs_t plan[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic [3:0] tr_cmd[$];
  logic [3:0] tr_adr[$];
  logic [3:0] tr_data[$];
  logic       tr_valid[$];
  logic       tr_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] lfsr_step(input logic [3:0] d);
    return {d[2:0], d[3] ^ d[2]};
  endfunction

  // Whole-run expectation from the rules: beats, gap cycles, then the done cycle.
  task automatic build_plan();
    obs_t       b;
    obs_t       last;
    logic [3:0] c0;
    logic [3:0] d;
    int         k, off;
    c0   = (cmd_sel == 4'd0) ? 4'd1 : cmd_sel;
    d    = (seed == 4'd0) ? 4'd1 : seed;
    last = '{cmd: 4'd0, adr: exp_o.adr, data: exp_o.data, valid: 1'b0, busy: 1'b0, done: 1'b0};
    for (int i = 0; i < int'(count); i++) begin
      if (mode == 2'd2) begin
        k = i / 16; off = i % 16;
      end else if (mode == 2'd1) begin
        k = i; off = i;
      end else begin
        k = 0; off = i;
      end
      b.cmd   = 4'(((int'(c0) - 1 + k) % 15) + 1);
      b.adr   = 4'(int'(adr_start) + off * int'(adr_stride));
      b.data  = d;
      b.valid = 1'b1;
      b.busy  = 1'b1;
      b.done  = 1'b0;
      plan.push_back(b);
      last = b;
      if (i < int'(count) - 1) begin
        for (int g = 0; g < int'(gap); g++) begin
          plan.push_back('{cmd: 4'd0, adr: b.adr, data: b.data, valid: 1'b0, busy: 1'b1, done: 1'b0});
        end
      end
      d = lfsr_step(d);
    end
    plan.push_back('{cmd: 4'd0, adr: last.adr, data: last.data, valid: 1'b0, busy: 1'b1, done: 1'b1});
  endtask

  // Compare on the falling edge, then advance the model using the inputs the next edge will see.
  always @(negedge clk) begin
    obs_t a;
    a = {bus.cmd, bus.adr, bus.data, bus.valid, busy, done};
    if (rst) begin
      plan.delete();
      exp_o = '0;
      check("reset_outputs", 32'(a), 32'd0);
    end else begin
      check("cycle", 32'(a), 32'(exp_o));
      if (a.busy) begin
        tr_cmd.push_back(a.cmd);
        tr_adr.push_back(a.adr);
        tr_data.push_back(a.data);
        tr_valid.push_back(a.valid);
        tr_done.push_back(a.done);
      end
      if (exp_o.busy && abort) begin
        plan.delete();
        exp_o = '{cmd: 4'd0, adr: exp_o.adr, data: exp_o.data, valid: 1'b0, busy: 1'b0, done: 1'b0};
      end else if (!exp_o.busy && start) begin
        build_plan();
        exp_o = plan.pop_front();
      end else if (plan.size() > 0) begin
        exp_o = plan.pop_front();
      end else begin
        exp_o = '{cmd: 4'd0, adr: exp_o.adr, data: exp_o.data, valid: 1'b0, busy: 1'b0, done: 1'b0};
      end
    end
  end

  function automatic logic [3:0] t_cmd(input int i);
    return (i < tr_cmd.size()) ? tr_cmd[i] : 4'hx;
  endfunction
  function automatic logic [3:0] t_adr(input int i);
    return (i < tr_adr.size()) ? tr_adr[i] : 4'hx;
  endfunction
  function automatic logic [3:0] t_data(input int i);
    return (i < tr_data.size()) ? tr_data[i] : 4'hx;
  endfunction
  function automatic logic t_valid(input int i);
    return (i < tr_valid.size()) ? tr_valid[i] : 1'bx;
  endfunction
  function automatic logic t_done(input int i);
    return (i < tr_done.size()) ? tr_done[i] : 1'bx;
  endfunction

  task automatic cfg(input logic [1:0] m, input logic [3:0] cs, input logic [3:0] as,
                     input logic [3:0] st, input logic [7:0] cn, input logic [3:0] gp,
                     input logic [3:0] sd);
    mode = m; cmd_sel = cs; adr_start = as; adr_stride = st; count = cn; gap = gp; seed = sd;
  endtask

  // Launch a run and wait (bounded) for busy to drop; optional stray start / abort at a cycle offset.
  task automatic run(input int extra_start_at, input int abort_at);
    int cyc;
    tr_cmd.delete(); tr_adr.delete(); tr_data.delete(); tr_valid.delete(); tr_done.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      if (cyc == extra_start_at) begin
        start = 1'b1; cmd_sel = 4'd9; count = 8'd1; adr_start = 4'd7;
      end
      if (cyc == abort_at) abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      cyc++;
    end
    check("run_ends", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int nv;
    int e_cmd[8];
    int e_val[8];

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({bus.cmd, bus.adr, bus.data, bus.valid, busy, done}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // FIXED back-to-back
    cfg(2'd0, 4'd5, 4'd2, 4'd3, 8'd3, 4'd0, 4'd3);
    run(-1, -1);
    check("fixed_len", 32'(tr_cmd.size()), 32'd4);
    check("fixed_b0", 32'({t_cmd(0), t_adr(0), t_data(0)}), 32'h523);
    check("fixed_b1", 32'({t_cmd(1), t_adr(1), t_data(1)}), 32'h556);
    check("fixed_b2", 32'({t_cmd(2), t_adr(2), t_data(2)}), 32'h58d);
    check("fixed_valid", 32'({t_valid(0), t_valid(1), t_valid(2), t_valid(3)}), 32'b1110);
    check("fixed_done", 32'(t_done(3)), 32'd1);

    // address wrap and zero seed / zero cmd_sel
    cfg(2'd0, 4'd0, 4'd14, 4'd3, 8'd3, 4'd0, 4'd0);
    run(-1, -1);
    check("wrap_b0", 32'({t_cmd(0), t_adr(0), t_data(0)}), 32'h1e1);
    check("wrap_b1", 32'({t_cmd(1), t_adr(1), t_data(1)}), 32'h112);
    check("wrap_b2", 32'({t_cmd(2), t_adr(2), t_data(2)}), 32'h144);

    // CMD_SWEEP with gap
    cfg(2'd1, 4'd14, 4'd0, 4'd1, 8'd3, 4'd2, 4'd5);
    run(-1, -1);
    e_cmd = '{14, 0, 0, 15, 0, 0, 1, 0};
    e_val = '{1, 0, 0, 1, 0, 0, 1, 0};
    check("sweep_len", 32'(tr_cmd.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("sweep_cmd", 32'(t_cmd(i)), 32'(e_cmd[i]));
      check("sweep_valid", 32'(t_valid(i)), 32'(e_val[i]));
    end

    // CROSS over 32 beats, with a stray start pulse mid-run
    cfg(2'd2, 4'd1, 4'd0, 4'd1, 8'd32, 4'd0, 4'd1);
    run(5, -1);
    check("cross_len", 32'(tr_cmd.size()), 32'd33);
    for (int i = 0; i < 32; i++) begin
      check("cross_adr", 32'(t_adr(i)), 32'(i % 16));
      check("cross_cmd", 32'(t_cmd(i)), (i < 16) ? 32'd1 : 32'd2);
    end
    check("cross_done", 32'(t_done(32)), 32'd1);

    // count = 0
    cfg(2'd0, 4'd3, 4'd0, 4'd1, 8'd0, 4'd0, 4'd1);
    run(-1, -1);
    check("zero_len", 32'(tr_cmd.size()), 32'd1);
    check("zero_done", 32'({t_valid(0), t_done(0)}), 32'b01);

    // abort during GAP
    cfg(2'd1, 4'd2, 4'd0, 4'd1, 8'd4, 4'd3, 4'd1);
    run(-1, 1);
    check("abort_len", 32'(tr_cmd.size()), 32'd2);
    check("abort_nodone", 32'({t_done(0), t_done(1)}), 32'b00);
    check("abort_idle", 32'({bus.cmd, bus.valid, busy, done}), 32'd0);

    // clean run after abort
    cfg(2'd0, 4'd6, 4'd1, 4'd2, 8'd2, 4'd0, 4'd2);
    run(-1, -1);
    check("post_abort_b0", 32'({t_cmd(0), t_adr(0), t_data(0)}), 32'h612);
    check("post_abort_b1", 32'({t_cmd(1), t_adr(1), t_data(1)}), 32'h634);

    // asynchronous reset mid-ISSUE
    cfg(2'd0, 4'd7, 4'd3, 4'd1, 8'd10, 4'd0, 4'd9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({bus.cmd, bus.adr, bus.data, bus.valid, busy, done}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // clean run after reset
    cfg(2'd0, 4'd4, 4'd5, 4'd1, 8'd2, 4'd0, 4'd0);
    run(-1, -1);
    check("post_reset_b0", 32'({t_cmd(0), t_adr(0), t_data(0)}), 32'h451);
    check("post_reset_b1", 32'({t_cmd(1), t_adr(1), t_data(1)}), 32'h462);

    // maximum count
    cfg(2'd0, 4'd1, 4'd0, 4'd1, 8'd255, 4'd0, 4'd1);
    run(-1, -1);
    nv = 0;
    foreach (tr_valid[i]) nv += int'(tr_valid[i]);
    check("max_count_beats", 32'(nv), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/dut_cmd_gen.md
Name: dut_cmd_gen

Overview:
Master-side command generator that drives the cmd/adr/data bundle of dut_if through its master modport, which coverage collectors sample on every posedge clk. It runs programmable command/address sweeps so that unique cmd x adr coverage bins are hit deterministically, instead of relying on random stimulus. It sits in the bench next to dut_if; its outputs connect directly to dut_if.cmd, adr and data.

Parameters:
CMD_W, 4, width of cmd
ADR_W, 4, width of adr
DATA_W, 4, width of data; the LFSR is defined for 4 only
CNT_W, 8, width of the beat counter and the count input

Ports:
clk  input  1  interface clock, same as dut_if.clk
rst  input  1  reset; asynchronous, active-high
start  input  1  launch a run; sampled only in IDLE
abort  input  1  terminate the current run
mode  input  2  0=FIXED, 1=CMD_SWEEP, 2=CROSS, 3=reserved (behaves as FIXED)
cmd_sel  input  CMD_W  initial cmd; 0 is replaced by 1
adr_start  input  ADR_W  first address
adr_stride  input  ADR_W  address increment per beat
count  input  CNT_W  number of beats
gap  input  4  idle cycles between beats
data_seed  input  DATA_W  LFSR seed; 0 is replaced by 1
cmd  output  CMD_W  command; 0 = NOP
adr  output  ADR_W  address
data  output  DATA_W  write data
valid  output  1  high on beat cycles
busy  output  1  run in progress
done  output  1  one-cycle pulse at normal completion

Behaviour:
- Reset (asynchronous, any state): state=IDLE; cmd=0, adr=0, data=0, valid=0, busy=0, done=0; all latched configuration cleared.
- All outputs are registered. No combinational path exists from any input to any output.
- States: IDLE, ISSUE, GAP, DONE.
- IDLE:
  - On start=1, latch mode/cmd_sel/adr_start/adr_stride/count/gap/data_seed and clear beat index i.
  - count=0 -> DONE; otherwise -> ISSUE.
  - start is ignored in every other state.
- ISSUE: one beat per cycle; valid=1, busy=1.
  - First beat appears on the cycle after start is sampled (latency 1).
  - After beat i, if i==count-1 -> DONE.
  - Otherwise, gap>0 -> GAP; gap==0 -> ISSUE (back-to-back beats).
- GAP: lasts exactly gap cycles; cmd=0, valid=0, adr/data hold; then -> ISSUE.
- DONE: lasts one cycle; done=1, busy=1, cmd=0, valid=0; then -> IDLE.
- IDLE outputs: cmd=0, valid=0, busy=0; adr/data hold their last values.
- abort=1 in ISSUE/GAP/DONE:
  - Next state is IDLE; cmd=0, valid=0, busy=0.
  - done is not pulsed.
  - abort has priority over every other transition.
  - abort in IDLE has no effect.
- Beat values (c0 = cmd_sel, or 1 if cmd_sel==0; all arithmetic modulo 2^W):
  - FIXED: cmd=c0; adr=adr_start + i*adr_stride.
  - CMD_SWEEP: cmd=c0 advanced i steps through the sequence 1..15, wrapping 15 -> 1 so 0 is never issued; adr as in FIXED.
  - CROSS: adr=adr_start + (i mod 16)*adr_stride; cmd=c0 advanced floor(i/16) steps through the 1..15 sequence.
- data:
  - Beat 0 carries the seed (0 is replaced by 1).
  - Each later beat carries LFSR next(d) = {d[2:0], d[3]^d[2]} (x^4+x^3+1, period 15).
  - The LFSR does not advance during GAP.
- The beat counter is CNT_W bits; count=255 gives exactly 255 beats.

Decomposition:
- Package dut_cmd_pkg:
  - mode enum: MODE_FIXED, MODE_CMD_SWEEP, MODE_CROSS.
  - state enum.
  - CMD_NOP = 0.
  - function cmd_inc(c), implementing the 1..15 wrap.
  - function lfsr4_next(d).
- One sub-module, dut_cmd_lfsr: seed load, zero-seed fixup, advance enable, asynchronous reset.

Test Plan:
- FIXED, cmd_sel=5, adr_start=2, stride=3, count=3, gap=0 -> valid on 3 consecutive cycles, (cmd,adr)=(5,2),(5,5),(5,8); done pulses on the next cycle, then busy=0.
- Address wrap, adr_start=14, stride=3, count=3 -> adr=14,1,4. Seed=0 -> data=1,2,4.
- CMD_SWEEP, cmd_sel=14, count=3, gap=2 -> valid pattern 1,0,0,1,0,0,1; cmd=14,0,0,15,0,0,1.
- CROSS, cmd_sel=1, stride=1, count=32 -> adr runs 0..15 twice; cmd=1 for beats 0-15 and 2 for beats 16-31; done after beat 31.
- count=0 -> no valid cycles; done=1 on the cycle after start. A start pulse while busy -> ignored, run unaffected.
- Mid-run events:
  - abort during GAP -> next cycle IDLE, cmd=0, busy=0, no done.
  - rst asserted mid-ISSUE -> all outputs 0 immediately (asynchronous).
  - A new start after either -> clean run from beat 0.
